wgt_load_ctrl: RTL and testbench

Weight-load sequencer for the weight pre-processing unit. On a start pulse it walks the 64-entry (8x8) weight buffer in address order, presents each weight and address to the pre-processing unit, and drives its active-low load enable (`load_mem_done`). While loading it counts, per column, the weights that need a compensation entry. It flags columns that exceed the compensation budget so the scheduler can fall back to full-precision mapping for them.

---
 rtl/wgt_load_ctrl.sv | 144 ++++++++++++++
 tb/tb_wgt_load_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wgt_load_ctrl.sv
// Weight-load sequencer: walks the weight buffer in address order, presents each
// weight to the pre-processing unit and gathers per-column compensation statistics.
module wgt_load_ctrl #(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned ROW_W    = 3,
    parameter int unsigned MAX_COMP = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            abort,
    input  logic                            hold,
    output logic                            wb_rd_en,
    output logic [ADDR_W-1:0]               wb_rd_addr,
    input  logic [7:0]                      wb_rd_data,
    output logic [7:0]                      wpu_weight,
    output logic [ADDR_W-1:0]               wpu_addr,
    output logic                            load_mem_done,
    output logic                            busy,
    output logic                            done,
    output logic [(2**(ADDR_W-ROW_W))-1:0]  col_overflow,
    output logic [ADDR_W:0]                 comp_total
);

    localparam int unsigned ColW   = ADDR_W - ROW_W;
    localparam int unsigned NumCol = 2**ColW;

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic                     rd_vld_q, rd_vld_d;
    logic [ADDR_W-1:0]        wpu_addr_q, wpu_addr_d;
    logic                     done_q, done_d;
    logic                     clear_stats;
    logic [NumCol-1:0][2:0]   cnt_q, cnt_d;
    logic [NumCol-1:0]        ovf_q, ovf_d;
    logic [ADDR_W:0]          total_q, total_d;
    logic                     is_comp;
    logic [ColW-1:0]          col_idx;

    // Next-state, read issue and status decode.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        done_d      = 1'b0;
        clear_stats = 1'b0;
        wb_rd_en    = 1'b0;
        busy        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StRead;
                    addr_d      = '0;
                    clear_stats = 1'b1;
                end
            end
            StRead: begin
                busy     = 1'b1;
                wb_rd_en = ~hold;
                if (!hold) begin
                    // Last address moves to DRAIN; the counter never wraps on its own.
                    if (addr_q == '1) begin
                        state_d = StDrain;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
                if (abort) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                busy    = 1'b1;
                state_d = StIdle;
                done_d  = ~abort;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Presentation pipeline: valid flag and address follow the issuing cycle.
    always_comb begin
        rd_vld_d   = wb_rd_en & ~abort;
        wpu_addr_d = wb_rd_en ? addr_q : wpu_addr_q;
    end

    assign is_comp = (wb_rd_data[7:4] != 4'h0) && (wb_rd_data[7:4] != 4'hF);
    assign col_idx = wpu_addr_q[ADDR_W-1:ROW_W];

    // Compensation statistics: saturating column counters, sticky overflow, total.
    always_comb begin
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        total_d = total_q;
        if (clear_stats) begin
            cnt_d   = '0;
            ovf_d   = '0;
            total_d = '0;
        end else if (rd_vld_q && is_comp) begin
            total_d = total_q + (ADDR_W + 1)'(1);
            if (cnt_q[col_idx] != 3'd7) begin
                cnt_d[col_idx] = cnt_q[col_idx] + 3'd1;
            end
            if (cnt_q[col_idx] == 3'(MAX_COMP)) begin
                ovf_d[col_idx] = 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            rd_vld_q   <= 1'b0;
            wpu_addr_q <= '0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            ovf_q      <= '0;
            total_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_vld_q   <= rd_vld_d;
            wpu_addr_q <= wpu_addr_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            total_q    <= total_d;
        end
    end

    assign wb_rd_addr    = addr_q;
    assign wpu_weight    = wb_rd_data;
    assign wpu_addr      = wpu_addr_q;
    assign load_mem_done = ~rd_vld_q;
    assign done          = done_q;
    assign col_overflow  = ovf_q;
    assign comp_total    = total_q;

endmodule

// File: tb/tb_wgt_load_ctrl.sv
// Directed bench for wgt_load_ctrl with a weight-buffer model and an
// address/weight scoreboard.
module tb_wgt_load_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       hold;
    logic       wb_rd_en;
    logic [5:0] wb_rd_addr;
    logic [7:0] wb_rd_data;
    logic [7:0] wpu_weight;
    logic [5:0] wpu_addr;
    logic       load_mem_done;
    logic       busy;
    logic       done;
    logic [7:0] col_overflow;
    logic [6:0] comp_total;

    typedef struct {
        logic [5:0] a;
        logic [7:0] w;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mem [64];
    int         checks = 0;
    int         passes = 0;
    int         fails  = 0;
    int         presented = 0;

    always #5 clk = ~clk;

    // Weight buffer model: one-cycle read latency.
    always @(posedge clk) begin
        if (wb_rd_en) wb_rd_data <= mem[wb_rd_addr];
    end

    wgt_load_ctrl #(
        .ADDR_W   (6),
        .ROW_W    (3),
        .MAX_COMP (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .hold          (hold),
        .wb_rd_en      (wb_rd_en),
        .wb_rd_addr    (wb_rd_addr),
        .wb_rd_data    (wb_rd_data),
        .wpu_weight    (wpu_weight),
        .wpu_addr      (wpu_addr),
        .load_mem_done (load_mem_done),
        .busy          (busy),
        .done          (done),
        .col_overflow  (col_overflow),
        .comp_total    (comp_total)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample 1 time unit after the edge, score any presented word.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (load_mem_done === 1'b0) begin
            presented++;
            chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wpu_addr", 64'(wpu_addr), 64'(e.a));
                chk("wpu_weight", 64'(wpu_weight), 64'(e.w));
            end
        end
    endtask

    // Reference statistics straight from the buffer contents.
    task automatic model_stats(output logic [6:0] total, output logic [7:0] ovf);
        int n;
        total = '0;
        ovf   = '0;
        for (int c = 0; c < 8; c++) begin
            n = 0;
            for (int r = 0; r < 8; r++) begin
                if (mem[c*8+r][7:4] != 4'h0 && mem[c*8+r][7:4] != 4'hF) n++;
            end
            total = total + 7'(n);
            ovf[c] = (n > 3);
        end
    endtask

    // Start a load; hold in cycles [hold_from, hold_from+hold_len), abort in cycle abort_at.
    // Cycle 1 is the first cycle after the edge that samples start.
    task automatic run_load(input int hold_from, input int hold_len, input int abort_at,
                            output int done_cyc);
        int c;
        sb.delete();
        for (int i = 0; i < 64; i++) sb.push_back('{a: 6'(i), w: mem[i]});
        presented = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 1;
        chk("first_rd_en", 64'(wb_rd_en), 64'd1);
        chk("first_rd_addr", 64'(wb_rd_addr), 64'd0);
        chk("first_ldm", 64'(load_mem_done), 64'd1);
        chk("busy_read", 64'(busy), 64'd1);
        chk("total_cleared", 64'(comp_total), 64'd0);
        chk("ovf_cleared", 64'(col_overflow), 64'd0);
        done_cyc = 0;
        while (c < 200 && done_cyc == 0) begin
            hold  = (c >= hold_from) && (c < hold_from + hold_len);
            abort = (c == abort_at);
            #1;
            if (hold) chk("hold_no_rd", 64'(wb_rd_en), 64'd0);
            tick();
            c++;
            hold  = 1'b0;
            abort = 1'b0;
            if (done === 1'b1) done_cyc = c;
            if (c == hold_from + 1) chk("hold_gap_ldm", 64'(load_mem_done), 64'd1);
            if (c == abort_at + 1) begin
                chk("abort_busy", 64'(busy), 64'd0);
                chk("abort_ldm", 64'(load_mem_done), 64'd1);
                sb.delete();
            end
        end
    endtask

    task automatic check_full(input string name, input int done_cyc, input int exp_cyc);
        logic [6:0] et;
        logic [7:0] eo;
        model_stats(et, eo);
        chk({name, "_done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
        chk({name, "_presented"}, 64'(presented), 64'd64);
        chk({name, "_sb_drained"}, 64'(sb.size()), 64'd0);
        chk({name, "_comp_total"}, 64'(comp_total), 64'(et));
        chk({name, "_col_overflow"}, 64'(col_overflow), 64'(eo));
        tick();
        chk({name, "_done_pulse"}, 64'(done), 64'd0);
        chk({name, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int dc;
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        hold = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h05;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_en", 64'(wb_rd_en), 64'd0);
        chk("rst_rd_addr", 64'(wb_rd_addr), 64'd0);
        chk("rst_wpu_addr", 64'(wpu_addr), 64'd0);
        chk("rst_ldm", 64'(load_mem_done), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(col_overflow), 64'd0);
        chk("rst_total", 64'(comp_total), 64'd0);
        rst = 1'b1;
        tick();

        // Non-compensating fill.
        run_load(1000, 0, 1000, dc);
        check_full("fill05", dc, 66);

        // Column 2 all compensating.
        for (int i = 0; i < 64; i++) mem[i] = (i >= 16 && i < 24) ? 8'h35 : 8'hF2;
        run_load(1000, 0, 1000, dc);
        check_full("col2", dc, 66);

        // Column 5 exactly at budget, then one over.
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        for (int i = 40; i < 43; i++) mem[i] = 8'h70;
        run_load(1000, 0, 1000, dc);
        check_full("col5_at", dc, 66);
        mem[45] = 8'h70;
        run_load(1000, 0, 1000, dc);
        check_full("col5_over", dc, 66);

        // Hold for 5 cycles right after address 10 is issued (cycle 11).
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        run_load(12, 5, 1000, dc);
        check_full("hold", dc, 71);

        // Abort one cycle after address 30 is issued; then restart cleanly.
        run_load(1000, 0, 32, dc);
        chk("abort_no_done", 64'(dc), 64'd0);
        chk("abort_presented", 64'(presented), 64'd31);
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        run_load(1000, 0, 1000, dc);
        check_full("restart", dc, 66);

        // Asynchronous reset once address 40 has been issued (cycle 41).
        for (int i = 0; i < 64; i++) mem[i] = 8'h44;
        sb.delete();
        for (int i = 0; i < 64; i++) sb.push_back('{a: 6'(i), w: mem[i]});
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 41; c++) tick();
        chk("pre_rst_addr", 64'(wb_rd_addr), 64'd40);
        rst = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_rd_en", 64'(wb_rd_en), 64'd0);
        chk("mid_rst_rd_addr", 64'(wb_rd_addr), 64'd0);
        chk("mid_rst_wpu_addr", 64'(wpu_addr), 64'd0);
        chk("mid_rst_ldm", 64'(load_mem_done), 64'd1);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_total", 64'(comp_total), 64'd0);
        chk("mid_rst_ovf", 64'(col_overflow), 64'd0);
        tick();
        rst = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            chk("post_rst_rd_en", 64'(wb_rd_en), 64'd0);
            chk("post_rst_done", 64'(done), 64'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
